// File: rtl/inbuf_offset_cal.sv
// Input-buffer offset calibration: sweeps the osc trim code from -7 to +7 and reports the code where
// the comparator output flips from 0 to 1. Optional debug outputs are enabled by INBUF_CAL_DBG_EN.
module inbuf_offset_cal #(
   parameter int SETTLE_CYC  = 16,
   parameter int SAMPLES     = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             ibuf_o,
   output logic [3:0]                       osc,
   output logic                             osc_en,
   output logic                             busy,
   output logic                             done,
   output logic                             cal_ok,
   output logic [3:0]                       cal_code
`ifdef INBUF_CAL_DBG_EN
   ,
   output logic [3:0]                       dbg_code,
   output logic [$clog2(SAMPLES+1)-1:0]     dbg_ones
`endif
);

   localparam int OW   = $clog2(SAMPLES + 1);
   localparam int CMAX = (SETTLE_CYC > SAMPLES) ? SETTLE_CYC : SAMPLES;
   localparam int CW   = $clog2(CMAX);

   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);
   localparam logic [OW:0]   SAMPLES_W   = (OW + 1)'(SAMPLES);
   localparam logic [3:0]    IDX_LAST    = 4'd14;
   localparam logic [3:0]    CODE_NEG7   = 4'b0111;
   localparam logic [3:0]    CODE_POS7   = 4'b1111;
   localparam logic [3:0]    CODE_ZERO   = 4'b1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_DONE
   } state_t;

   // Sweep index 0..14 -> value idx-7 in sign/magnitude form; -0 is never produced.
   function automatic logic [3:0] code_of(input logic [3:0] idx);
      logic [2:0] mag;
      if (idx < 4'd7) begin
         mag = 3'd7 - idx[2:0];
         return {1'b0, mag};
      end
      mag = idx[2:0] - 3'd7;
      return {1'b1, mag};
   endfunction

   state_t                 state_q, state_d;
   logic [3:0]             idx_q, idx_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [OW-1:0]          ones_q, ones_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [3:0]             osc_q, osc_d;
   logic                   osc_en_q, osc_en_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   cal_ok_q, cal_ok_d;
   logic [3:0]             cal_code_q, cal_code_d;

   logic                   ibuf_sync;
   logic [OW:0]            twice_ones;
   logic                   flipped;
   logic [3:0]             result_code;

   assign ibuf_sync  = sync_q[SYNC_STAGES-1];
   assign twice_ones = {ones_q, 1'b0};
   // An exact half-and-half split counts as not flipped.
   assign flipped    = (twice_ones > SAMPLES_W);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      ones_d      = ones_q;
      sync_d      = {sync_q[SYNC_STAGES-2:0], ibuf_o};
      osc_d       = osc_q;
      osc_en_d    = osc_en_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cal_ok_d    = cal_ok_q;
      cal_code_d  = cal_code_q;
      result_code = CODE_POS7;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d    = 4'd0;
               cnt_d    = '0;
               ones_d   = '0;
               osc_d    = CODE_NEG7;
               osc_en_d = 1'b1;
               busy_d   = 1'b1;
               cal_ok_d = 1'b0;
               state_d  = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_SAMPLE: begin
            if (ibuf_sync) begin
               ones_d = ones_q + 1'b1;
            end
            if (cnt_q == SAMPLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_EVAL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_EVAL: begin
            cnt_d  = '0;
            ones_d = '0;
            if (flipped || (idx_q == IDX_LAST)) begin
               if (flipped) begin
                  result_code = (idx_q == 4'd0) ? CODE_NEG7 : osc_q;
               end else begin
                  result_code = CODE_POS7;
               end
               cal_ok_d   = flipped && (idx_q != 4'd0);
               cal_code_d = result_code;
               osc_d      = result_code;
               osc_en_d   = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               state_d    = ST_DONE;
            end else begin
               idx_d   = idx_q + 4'd1;
               osc_d   = code_of(idx_q + 4'd1);
               state_d = ST_SETTLE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= 4'd0;
         cnt_q      <= '0;
         ones_q     <= '0;
         sync_q     <= '0;
         osc_q      <= CODE_ZERO;
         osc_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cal_ok_q   <= 1'b0;
         cal_code_q <= CODE_ZERO;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         ones_q     <= ones_d;
         sync_q     <= sync_d;
         osc_q      <= osc_d;
         osc_en_q   <= osc_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cal_ok_q   <= cal_ok_d;
         cal_code_q <= cal_code_d;
      end
   end

   assign osc      = osc_q;
   assign osc_en   = osc_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign cal_ok   = cal_ok_q;
   assign cal_code = cal_code_q;

`ifdef INBUF_CAL_DBG_EN
   logic [3:0]    dbg_code_q, dbg_code_d;
   logic [OW-1:0] dbg_ones_q, dbg_ones_d;

   // Snapshot of the code under test and its ones count at every evaluation.
   always_comb begin
      dbg_code_d = dbg_code_q;
      dbg_ones_d = dbg_ones_q;
      if (state_q == ST_EVAL) begin
         dbg_code_d = osc_q;
         dbg_ones_d = ones_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_code_q <= CODE_ZERO;
         dbg_ones_q <= '0;
      end else begin
         dbg_code_q <= dbg_code_d;
         dbg_ones_q <= dbg_ones_d;
      end
   end

   assign dbg_code = dbg_code_q;
   assign dbg_ones = dbg_ones_q;
`endif

endmodule
